// File: rtl/synth_sched_pkg.sv
// synth_sched_pkg
//   Shared types and helper functions for the oscillator/envelope slot
//   scheduler. It holds the frame state enum and the constant functions
//   that size the per-frame cycle counter and the slot index ports.
//   This package has no ports.

package synth_sched_pkg;

    // Frame sequencer states: wait for a word-clock edge, step the slots,
    // then spend one cycle flagging the end of the frame.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } SchedState;

    // Width needed to hold an index in 0..count-1. The result is never
    // below one bit, so a single voice or a one-cycle phase still gets a
    // legal vector.
    function automatic int idxWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Number of OSC_CLK cycles the RUN state occupies in each frame.
    function automatic int frameCycles(input int voices,
                                       input int oscPerVoice,
                                       input int slotCycles);
        return voices * oscPerVoice * slotCycles;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Brings an asynchronous level (typically a word clock) into the CLK
//   domain through two flops. It then emits a one-cycle registered pulse
//   on each rising edge of the synchronized level.
//
//   Ports:
//     CLK        in   rising-edge clock of the destination domain
//     iRST_N     in   asynchronous active-low reset
//     asyncIn    in   level from another clock domain
//     risePulse  out  one-cycle pulse, registered, on a synchronized rise
//
//   Timing: the pulse is visible two cycles after the edge that first
//   samples asyncIn high.

module sync_edge_det (
    input  logic CLK,
    input  logic iRST_N,
    input  logic asyncIn,
    output logic risePulse
);

    logic metaQ;
    logic syncQ;
    logic syncDly;

    // Two-stage synchronizer, a delayed copy for edge detection, and the
    // registered edge pulse. All of them clear to 0 in reset. An input
    // that is already high at reset release is therefore seen as a rise.
    always_ff @(posedge CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            metaQ     <= 1'b0;
            syncQ     <= 1'b0;
            syncDly   <= 1'b0;
            risePulse <= 1'b0;
        end else begin
            metaQ     <= asyncIn;
            syncQ     <= metaQ;
            syncDly   <= syncQ;
            risePulse <= syncQ & ~syncDly;
        end
    end

endmodule

// File: rtl/osc_slot_scheduler.sv
// osc_slot_scheduler
//   Frame-level sequencer for the time-multiplexed oscillator and envelope
//   datapath. Each synchronized rising edge of LRCK_1X, when accepted,
//   starts one frame. During the frame, every (voice, oscillator) slot and
//   every (voice, envelope) slot is stepped exactly once, using one-cycle
//   strobes plus slot indices. Oscillator slots are SLOT_CYCLES long and
//   envelope slots are half that length, so both sets fit in the same
//   N = VOICES*V_OSC*SLOT_CYCLES cycles.
//
//   Ports:
//     OSC_CLK        in   system clock, rising edge
//     iRST_N         in   asynchronous active-low reset
//     LRCK_1X        in   audio word clock, asynchronous to OSC_CLK
//     run_en         in   accept new frames while high
//     frame_start    out  pulse when a frame is accepted
//     frame_done     out  pulse one cycle after the last slot
//     busy           out  high while a frame is in progress (RUN/DONE)
//     osc_slot_stb   out  first cycle of each oscillator slot
//     osc_voice_idx  out  voice of the current oscillator slot
//     osc_idx        out  oscillator within that voice
//     env_stb        out  first cycle of each envelope slot
//     env_voice_idx  out  voice of the current envelope slot
//     env_idx        out  envelope within that voice
//     overrun        out  pulse when a frame event arrives while busy
//     overrun_cnt    out  saturating count of those dropped frames
//
//   Build option: define FRAME_OVERRUN_EN to enable overrun and
//   overrun_cnt. Without the macro, both outputs are tied to 0 and
//   dropped frames are discarded silently.
//
//   All outputs are registered.

module osc_slot_scheduler
    import synth_sched_pkg::*;
#(
    parameter int VOICES      = 8,
    parameter int V_OSC       = 4,
    parameter int V_ENVS      = 2 * V_OSC,
    parameter int SLOT_CYCLES = 8
) (
    input  logic                          OSC_CLK,
    input  logic                          iRST_N,
    input  logic                          LRCK_1X,
    input  logic                          run_en,
    output logic                          frame_start,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          osc_slot_stb,
    output logic [idxWidth(VOICES)-1:0]   osc_voice_idx,
    output logic [idxWidth(V_OSC)-1:0]    osc_idx,
    output logic                          env_stb,
    output logic [idxWidth(VOICES)-1:0]   env_voice_idx,
    output logic [idxWidth(V_ENVS)-1:0]   env_idx,
    output logic                          overrun,
    output logic [7:0]                    overrun_cnt
);

    localparam int N       = frameCycles(VOICES, V_OSC, SLOT_CYCLES);
    localparam int CNT_W   = idxWidth(N);
    localparam int OPH_W   = idxWidth(SLOT_CYCLES);
    localparam int EPH_W   = idxWidth(SLOT_CYCLES / 2);
    localparam int VOICE_W = idxWidth(VOICES);
    localparam int OSC_W   = idxWidth(V_OSC);
    localparam int ENV_W   = idxWidth(V_ENVS);

    SchedState          state, stateNext;
    logic [CNT_W-1:0]   cycCnt, cycCntNext;

    // The slot position is kept as incremental counters instead of being
    // divided out of cycCnt. Phase counts the cycles inside a slot. The
    // index counters carry into the voice counters.
    logic [OPH_W-1:0]   oscPhase, oscPhaseNext;
    logic [OSC_W-1:0]   oscCur, oscCurNext;
    logic [VOICE_W-1:0] oscVoice, oscVoiceNext;
    logic [EPH_W-1:0]   envPhase, envPhaseNext;
    logic [ENV_W-1:0]   envCur, envCurNext;
    logic [VOICE_W-1:0] envVoice, envVoiceNext;

    logic               frameStartNext;
    logic               frameDoneNext;
    logic               busyNext;
    logic               oscStbNext;
    logic [VOICE_W-1:0] oscVoiceIdxNext;
    logic [OSC_W-1:0]   oscIdxNext;
    logic               envStbNext;
    logic [VOICE_W-1:0] envVoiceIdxNext;
    logic [ENV_W-1:0]   envIdxNext;

    logic               frameEvent;

    sync_edge_det uLrckSync (
        .CLK       (OSC_CLK),
        .iRST_N    (iRST_N),
        .asyncIn   (LRCK_1X),
        .risePulse (frameEvent)
    );

    // State register, slot position counters, and the registered copies of
    // every output. The outputs are one cycle behind the position
    // counters. As a result, the strobe for counter value c appears in the
    // cycle after the edge that processes c.
    always_ff @(posedge OSC_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state         <= IDLE;
            cycCnt        <= '0;
            oscPhase      <= '0;
            oscCur        <= '0;
            oscVoice      <= '0;
            envPhase      <= '0;
            envCur        <= '0;
            envVoice      <= '0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            osc_slot_stb  <= 1'b0;
            osc_voice_idx <= '0;
            osc_idx       <= '0;
            env_stb       <= 1'b0;
            env_voice_idx <= '0;
            env_idx       <= '0;
        end else begin
            state         <= stateNext;
            cycCnt        <= cycCntNext;
            oscPhase      <= oscPhaseNext;
            oscCur        <= oscCurNext;
            oscVoice      <= oscVoiceNext;
            envPhase      <= envPhaseNext;
            envCur        <= envCurNext;
            envVoice      <= envVoiceNext;
            frame_start   <= frameStartNext;
            frame_done    <= frameDoneNext;
            busy          <= busyNext;
            osc_slot_stb  <= oscStbNext;
            osc_voice_idx <= oscVoiceIdxNext;
            osc_idx       <= oscIdxNext;
            env_stb       <= envStbNext;
            env_voice_idx <= envVoiceIdxNext;
            env_idx       <= envIdxNext;
        end
    end

    // Next-state and next-output logic. By default, pulses are low, and the
    // indices and counters hold. The indices therefore keep the last slot's
    // value between frames. Frame events seen in RUN or DONE fall through
    // unhandled here; they are never queued.
    always_comb begin
        stateNext       = state;
        cycCntNext      = cycCnt;
        oscPhaseNext    = oscPhase;
        oscCurNext      = oscCur;
        oscVoiceNext    = oscVoice;
        envPhaseNext    = envPhase;
        envCurNext      = envCur;
        envVoiceNext    = envVoice;
        frameStartNext  = 1'b0;
        frameDoneNext   = 1'b0;
        oscStbNext      = 1'b0;
        oscVoiceIdxNext = osc_voice_idx;
        oscIdxNext      = osc_idx;
        envStbNext      = 1'b0;
        envVoiceIdxNext = env_voice_idx;
        envIdxNext      = env_idx;

        case (state)
            IDLE: begin
                if (frameEvent && run_en) begin
                    stateNext      = RUN;
                    frameStartNext = 1'b1;
                    cycCntNext     = '0;
                    oscPhaseNext   = '0;
                    oscCurNext     = '0;
                    oscVoiceNext   = '0;
                    envPhaseNext   = '0;
                    envCurNext     = '0;
                    envVoiceNext   = '0;
                end
            end

            RUN: begin
                oscStbNext      = (oscPhase == '0);
                oscVoiceIdxNext = oscVoice;
                oscIdxNext      = oscCur;
                envStbNext      = (envPhase == '0);
                envVoiceIdxNext = envVoice;
                envIdxNext      = envCur;

                if (oscPhase == OPH_W'(SLOT_CYCLES - 1)) begin
                    oscPhaseNext = '0;
                    if (oscCur == OSC_W'(V_OSC - 1)) begin
                        oscCurNext   = '0;
                        oscVoiceNext = (oscVoice == VOICE_W'(VOICES - 1)) ? '0 : oscVoice + 1'b1;
                    end else begin
                        oscCurNext = oscCur + 1'b1;
                    end
                end else begin
                    oscPhaseNext = oscPhase + 1'b1;
                end

                if (envPhase == EPH_W'(SLOT_CYCLES / 2 - 1)) begin
                    envPhaseNext = '0;
                    if (envCur == ENV_W'(V_ENVS - 1)) begin
                        envCurNext   = '0;
                        envVoiceNext = (envVoice == VOICE_W'(VOICES - 1)) ? '0 : envVoice + 1'b1;
                    end else begin
                        envCurNext = envCur + 1'b1;
                    end
                end else begin
                    envPhaseNext = envPhase + 1'b1;
                end

                if (cycCnt == CNT_W'(N - 1)) begin
                    cycCntNext = '0;
                    stateNext  = DONE;
                end else begin
                    cycCntNext = cycCnt + 1'b1;
                end
            end

            DONE: begin
                frameDoneNext = 1'b1;
                stateNext     = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

`ifdef FRAME_OVERRUN_EN
    // A frame event that lands while a frame is already in progress is
    // dropped. It is reported one cycle later, and the running count stops
    // at 255 instead of wrapping.
    always_ff @(posedge OSC_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            overrun <= frameEvent && (state != IDLE);
            if (frameEvent && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end
`else
    assign overrun     = 1'b0;
    assign overrun_cnt = 8'd0;
`endif

endmodule
